// File: rtl/seq_detector_param.sv
// Serial pattern detector with a runtime-loadable W-bit pattern, overlapping or
// non-overlapping detection, a registered detect pulse and a saturating match counter.
module seq_detector_param #(
   parameter int unsigned    W         = 4,
   parameter int unsigned    CNT_W     = 8,
   parameter logic [W-1:0]   RESET_PAT = W'(4'b1011)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             x,
   input  logic             overlap,
   input  logic             pat_load,
   input  logic [W-1:0]     pat_in,
   output logic             F,
   output logic [CNT_W-1:0] match_cnt,
   output logic             cnt_sat
);

   localparam int unsigned      VW      = $clog2(W + 1);
   localparam logic [VW-1:0]    V_FULL  = VW'(W);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [W-1:0]     pat;
   logic [W-1:0]     hist;
   logic [W-1:0]     hist_nxt;
   logic [VW-1:0]    vcnt;
   logic [VW-1:0]    vcnt_inc;
   logic [VW-1:0]    vcnt_nxt;
   logic             match;
   logic [CNT_W-1:0] cnt_nxt;

   // Candidate state for an enabled sample; a non-overlapping match restarts the window.
   always_comb begin
      hist_nxt = {hist[W-2:0], x};
      vcnt_inc = (vcnt == V_FULL) ? vcnt : vcnt + VW'(1);
      match    = (vcnt_inc == V_FULL) && (hist_nxt == pat);
      vcnt_nxt = (match && !overlap) ? '0 : vcnt_inc;
      cnt_nxt  = (match && (match_cnt != CNT_MAX)) ? match_cnt + CNT_W'(1) : match_cnt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pat       <= RESET_PAT;
         hist      <= '0;
         vcnt      <= '0;
         F         <= 1'b0;
         match_cnt <= '0;
         cnt_sat   <= 1'b0;
      end else if (pat_load) begin
         pat       <= pat_in;
         hist      <= '0;
         vcnt      <= '0;
         F         <= 1'b0;
         match_cnt <= '0;
         cnt_sat   <= 1'b0;
      end else if (en) begin
         hist      <= hist_nxt;
         vcnt      <= vcnt_nxt;
         F         <= match;
         match_cnt <= cnt_nxt;
         cnt_sat   <= (cnt_nxt == CNT_MAX);
      end else begin
         F <= 1'b0;
      end
   end

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: directed vector table, hand-written corner sequences
// and randomized traffic against a sequence-level reference model.
module tb_seq_detector_param;

   localparam int unsigned W = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic             en, x, overlap, pat_load;
   logic [W-1:0]     pat_in;
   logic             f1, f2, sat1, sat2;
   logic [7:0]       cnt1;
   logic [1:0]       cnt2;

   int checks = 0;
   int errors = 0;

   seq_detector_param #(.W(W), .CNT_W(8), .RESET_PAT(4'b1011)) dut (
      .clk(clk), .rst(rst), .en(en), .x(x), .overlap(overlap), .pat_load(pat_load),
      .pat_in(pat_in), .F(f1), .match_cnt(cnt1), .cnt_sat(sat1));

   seq_detector_param #(.W(W), .CNT_W(2), .RESET_PAT(4'b1011)) dut2 (
      .clk(clk), .rst(rst), .en(en), .x(x), .overlap(overlap), .pat_load(pat_load),
      .pat_in(pat_in), .F(f2), .match_cnt(cnt2), .cnt_sat(sat2));

   always #5 clk = ~clk;

   // Reference model: the sampled bit sequence since reset/load, with the index at
   // which the current non-overlapping window may start.
   bit       bits[$];
   int       fresh;
   int       mcount;
   bit       exp_f;
   bit [W-1:0] pat_m;

   function automatic bit window_match();
      int i = bits.size() - 1;
      int s = i - int'(W) + 1;
      if (s < 0 || s < fresh) return 1'b0;
      for (int k = 0; k < int'(W); k++)
         if (bits[s + k] != pat_m[int'(W) - 1 - k]) return 1'b0;
      return 1'b1;
   endfunction

   function automatic void model_reset();
      pat_m = 4'b1011;
      bits.delete();
      fresh = 0; mcount = 0; exp_f = 1'b0;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_model();
      int sat_lim2 = 3;
      int sat_lim1 = 255;
      int c1 = (mcount > sat_lim1) ? sat_lim1 : mcount;
      int c2 = (mcount > sat_lim2) ? sat_lim2 : mcount;
      chk("F", int'(f1), int'(exp_f));
      chk("match_cnt", int'(cnt1), c1);
      chk("cnt_sat", int'(sat1), int'(c1 == sat_lim1));
      chk("F_w2", int'(f2), int'(exp_f));
      chk("match_cnt_w2", int'(cnt2), c2);
      chk("cnt_sat_w2", int'(sat2), int'(c2 == sat_lim2));
   endtask

   // One clock edge with the given inputs, model updated, outputs compared #1 later.
   task automatic step(input bit e, input bit xi, input bit ov, input bit ld, input bit [W-1:0] pin);
      en = e; x = xi; overlap = ov; pat_load = ld; pat_in = pin;
      @(posedge clk);
      if (ld) begin
         pat_m = pin; bits.delete(); fresh = 0; mcount = 0; exp_f = 1'b0;
      end else if (e) begin
         bits.push_back(xi);
         exp_f = window_match();
         if (exp_f) begin
            mcount++;
            if (!ov) fresh = bits.size();
         end
      end else begin
         exp_f = 1'b0;
      end
      #1;
      check_model();
   endtask

   // Asynchronous reset asserted between edges; outputs must clear without a clock.
   task automatic pulse_reset();
      rst = 1'b1;
      #2;
      chk("rst_F", int'(f1), 0);
      chk("rst_cnt", int'(cnt1), 0);
      chk("rst_sat", int'(sat1), 0);
      chk("rst_cnt_w2", int'(cnt2), 0);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
   endtask

   typedef struct {
      bit       rst_before;
      bit       en;
      bit       x;
      bit       ovl;
      bit       f;
      int       cnt;
   } vec_t;

   vec_t tbl[$];

   function automatic void add(bit r, bit e, bit xi, bit ov, bit f, int c);
      vec_t v;
      v.rst_before = r; v.en = e; v.x = xi; v.ovl = ov; v.f = f; v.cnt = c;
      tbl.push_back(v);
   endfunction

   initial begin
      bit ov_r;
      bit [3:0] s1;
      bit [9:0] s2;
      s1 = 4'b1011;

      // Overlapping: 1011011 -> pulses on 4th and 7th bits.
      add(1,1,1,1,0,0); add(0,1,0,1,0,0); add(0,1,1,1,0,0); add(0,1,1,1,1,1);
      add(0,1,0,1,0,1); add(0,1,1,1,0,1); add(0,1,1,1,1,2);
      // Non-overlapping: 1011 011 011 1011 -> pulses on bits 4, 10 and 14.
      add(1,1,1,0,0,0); add(0,1,0,0,0,0); add(0,1,1,0,0,0); add(0,1,1,0,1,1);
      add(0,1,0,0,0,1); add(0,1,1,0,0,1); add(0,1,1,0,0,1);
      add(0,1,0,0,0,1); add(0,1,1,0,0,1); add(0,1,1,0,1,2);
      add(0,1,1,0,0,2); add(0,1,0,0,0,2); add(0,1,1,0,0,2); add(0,1,1,0,1,3);
      // Enable gaps do not break a partial match.
      add(1,1,1,1,0,0); add(0,0,1,1,0,0); add(0,0,0,1,0,0); add(0,1,0,1,0,0);
      add(0,1,1,1,0,0); add(0,0,0,1,0,0); add(0,1,1,1,1,1);

      rst = 1'b1; en = 1'b0; x = 1'b0; overlap = 1'b1; pat_load = 1'b0; pat_in = '0;
      model_reset();
      #12;
      chk("reset_F", int'(f1), 0);
      chk("reset_cnt", int'(cnt1), 0);
      chk("reset_sat", int'(sat1), 0);
      @(negedge clk);
      rst = 1'b0;

      foreach (tbl[i]) begin
         if (tbl[i].rst_before) pulse_reset();
         step(tbl[i].en, tbl[i].x, tbl[i].ovl, 1'b0, '0);
         chk($sformatf("tbl%0d_F", i), int'(f1), int'(tbl[i].f));
         chk($sformatf("tbl%0d_cnt", i), int'(cnt1), tbl[i].cnt);
      end

      // Pattern load discards earlier bits and ignores x on the load edge.
      pulse_reset();
      step(1,1,1,0,'0); step(1,0,1,0,'0);
      step(1,1,1,1,4'b0110);
      s2 = 10'b0000110110;
      for (int k = 5; k >= 0; k--) step(1, s2[k], 1, 0, '0);
      chk("load_cnt", int'(cnt1), 1);

      // Saturation: pattern 1111, eight 1s, five overlapping matches.
      step(1,0,1,1,4'b1111);
      for (int k = 0; k < 8; k++) step(1,1,1,0,'0);
      chk("sat_cnt_w2", int'(cnt2), 3);
      chk("sat_flag_w2", int'(sat2), 1);
      chk("sat_cnt_w8", int'(cnt1), 5);

      // Mid-pattern reset restores the reset pattern and drops the partial match.
      pulse_reset();
      step(1,1,1,0,'0); step(1,0,1,0,'0); step(1,1,1,0,'0);
      pulse_reset();
      step(1,1,1,0,'0);
      for (int k = 3; k >= 0; k--) step(1, s1[k], 1, 0, '0);
      chk("post_rst_match", int'(cnt1), 1);

      // Randomized traffic.
      ov_r = 1'b1;
      for (int n = 0; n < 3000; n++) begin
         int r = int'($urandom_range(0, 199));
         if (r == 0) pulse_reset();
         else begin
            if ($urandom_range(0, 15) == 0) ov_r = ~ov_r;
            step($urandom_range(0, 3) != 0, 1'($urandom), ov_r, r >= 197, 4'($urandom));
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
